fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch sequencer on the consumer side of the program counter register.
//  Takes the current PC, fetches one instruction over a req/ack memory handshake,
//  holds it for the decoder, and returns the next PC to the PC register input.
//  The PC register has no enable, so this block drives pc_next = pc_in to hold.
// PARAMETERS
//  ADDR_W      8   PC / instruction-memory address width
//  DATA_W      8   instruction width
//  WAIT_LIMIT  15  cycles without imem_ack before fetch fault (1..255)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-high
//  pc_in        in   ADDR_W  current PC (PC register output)
//  pc_next      out  ADDR_W  next PC (PC register input), combinational
//  imem_req     out  1       fetch request, registered
//  imem_addr    out  ADDR_W  fetch address, registered
//  imem_ack     in   1       read data valid for the current request
//  imem_rdata   in   DATA_W  instruction data, sampled when imem_ack=1
//  ir           out  DATA_W  instruction register
//  ir_pc        out  ADDR_W  address ir was fetched from
//  ir_valid     out  1       ir holds an unconsumed instruction
//  dec_ready    in   1       decoder accepts ir this cycle
//  redirect     in   1       branch/jump taken; flush and restart at redirect_pc
//  redirect_pc  in   ADDR_W  redirect target
//  fetch_err    out  1       sticky fetch timeout fault
// BEHAVIOUR
//  States: IDLE, REQ, FULL, DROP, ERR. One instruction in flight, no prefetch.
//  Reset (async): state=IDLE; imem_req=0, imem_addr=0, ir=0, ir_pc=0, ir_valid=0,
//   fetch_err=0, wait counter=0. A reset during a pending request abandons it.
//  Memory protocol: imem_req and imem_addr stay stable from issue until the cycle
//   of imem_ack, inclusive. imem_ack seen in any state other than REQ/DROP is ignored.
//  Invariant: in REQ, imem_addr == pc_in.
//  pc_next priority:
//   1) ERR: pc_in.
//   2) redirect=1: redirect_pc.
//   3) REQ and imem_ack=1: pc_in+1, modulo 2^ADDR_W (0xFF -> 0x00).
//   4) Otherwise: pc_in.
//  When the next state is REQ and a new request is starting:
//   imem_addr <= pc_next and imem_req <= 1.
//  IDLE: always -> REQ on the next clock. The first imem_req is high one cycle
//   after reset is released.
//  REQ:
//   - ack & !redirect: ir<=imem_rdata, ir_pc<=pc_in, ir_valid<=1, imem_req<=0,
//     go to FULL.
//   - ack & redirect: discard data, stay in REQ, new request to redirect_pc.
//   - !ack & redirect: go to DROP. Request keeps the old imem_addr.
//  DROP: hold the old request until ack. Discard the data, then go to REQ
//   with a new request at pc_in (the redirect target).
//  FULL: ir, ir_pc and ir_valid are held.
//   - redirect: ir_valid<=0, go to REQ at redirect_pc. A dec_ready in the same
//     cycle does not count as consumption.
//   - dec_ready & !redirect: ir_valid<=0, go to REQ at pc_in.
//  Wait counter: cleared when a request is issued. Increments each REQ/DROP cycle
//   with imem_ack=0. Reaching WAIT_LIMIT -> ERR.
//  ERR: imem_req=0, ir_valid=0, fetch_err=1. Redirect and ack are ignored.
//   Only rst exits ERR.
//  Latency: 1-cycle memory gives ack->ir_valid of 1 cycle.
//   Throughput is 1 instruction per 3 cycles with no stalls.
// TESTING
//  1 Release rst, pc_in=0x00, ack 1 cycle after req, rdata=0xA5 -> req@addr 0x00;
//    pc_next=0x01 in the ack cycle; next cycle ir=0xA5, ir_pc=0x00, ir_valid=1.
//  2 Hold dec_ready=0 for 5 cycles in FULL -> ir stable, imem_req=0, pc_next=pc_in.
//    Raise dec_ready -> ir_valid=0, next req addr=0x01.
//  3 FULL with redirect=1, redirect_pc=0x40, dec_ready=1 -> ir_valid=0;
//    pc_next=0x40; next req addr=0x40.
//  4 Redirect to 0x40 in REQ with ack 3 cycles later (rdata=0x77) -> DROP holds
//    the old addr; 0x77 never reaches ir; then req addr=0x40.
//  5 Fetch at pc_in=0xFF with ack -> pc_next=0x00, ir_pc=0xFF.
//  6 No ack for WAIT_LIMIT=15 cycles -> fetch_err=1, imem_req=0, sticky across
//    redirect/ack. Assert rst mid-REQ -> outputs clear without a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch sequencer sitting after the program counter register.
//   It fetches one instruction at a time over a req/ack memory handshake,
//   holds it for the decoder, and computes the next PC. The PC register has
//   no enable, so holding the PC means driving o_pc_next = i_pc_in.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   i_pc_in        in   current PC (PC register output)
//   o_pc_next      out  next PC (PC register input), combinational
//   o_imem_req     out  fetch request, registered
//   o_imem_addr    out  fetch address, registered
//   i_imem_ack     in   read data valid for the current request
//   i_imem_rdata   in   instruction data, sampled on i_imem_ack
//   o_ir           out  instruction register
//   o_ir_pc        out  address o_ir was fetched from
//   o_ir_valid     out  o_ir holds an unconsumed instruction
//   i_dec_ready    in   decoder accepts o_ir this cycle
//   i_redirect     in   branch/jump taken: flush and restart at i_redirect_pc
//   i_redirect_pc  in   redirect target
//   o_fetch_err    out  sticky fetch timeout fault
//
// States
//   IDLE | out of reset, issues the first request on the next clock
//   REQ  | request outstanding, o_imem_addr == i_pc_in
//   FULL | instruction held in o_ir, waiting for the decoder
//   DROP | redirected while a request was outstanding; waits for and
//        | discards the stale response before refetching at i_pc_in
//   ERR  | memory never answered; only reset leaves this state
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int WAIT_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_pc_in,
    output logic [ADDR_W-1:0] o_pc_next,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [DATA_W-1:0] i_imem_rdata,
    output logic [DATA_W-1:0] o_ir,
    output logic [ADDR_W-1:0] o_ir_pc,
    output logic              o_ir_valid,
    input  logic              i_dec_ready,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_FULL = 3'd2,
        S_DROP = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [7:0] LP_LIMIT = 8'(WAIT_LIMIT);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_imem_req;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_ir_pc;
    logic              r_ir_valid;
    logic              r_fetch_err;
    logic [7:0]        r_wait_cnt;

    logic [ADDR_W-1:0] w_pc_next;
    logic [7:0]        w_cnt_inc;
    logic              w_timeout;
    logic              w_issue;
    logic              w_load_ir;
    logic              w_consume;
    logic              w_count;
    logic              w_to_err;

    assign w_cnt_inc = r_wait_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc == LP_LIMIT);

    always_comb begin
        w_pc_next = i_pc_in;
        if (r_state == S_ERR)
            w_pc_next = i_pc_in;
        else if (i_redirect)
            w_pc_next = i_redirect_pc;
        else if (r_state == S_REQ && i_imem_ack)
            w_pc_next = i_pc_in + ADDR_W'(1);
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_load_ir    = 1'b0;
        w_consume    = 1'b0;
        w_count      = 1'b0;
        w_to_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
                w_issue      = 1'b1;
            end
            S_REQ: begin
                if (i_imem_ack) begin
                    if (i_redirect) begin
                        // Response belongs to the flushed path: refetch at the target.
                        w_issue = 1'b1;
                    end else begin
                        w_load_ir    = 1'b1;
                        w_state_next = S_FULL;
                    end
                end else if (w_timeout) begin
                    w_to_err     = 1'b1;
                    w_state_next = S_ERR;
                end else begin
                    // The old request must stay stable until acked, so a
                    // redirect here only parks us in DROP.
                    w_count = 1'b1;
                    if (i_redirect)
                        w_state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (i_imem_ack) begin
                    w_issue      = 1'b1;
                    w_state_next = S_REQ;
                end else if (w_timeout) begin
                    w_to_err     = 1'b1;
                    w_state_next = S_ERR;
                end else begin
                    w_count = 1'b1;
                end
            end
            S_FULL: begin
                // A redirect flushes ir; a coincident dec_ready is not a consume.
                if (i_redirect || i_dec_ready) begin
                    w_consume    = 1'b1;
                    w_issue      = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_ERR: begin
                w_state_next = S_ERR;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_imem_req  <= 1'b0;
            r_imem_addr <= '0;
            r_ir        <= '0;
            r_ir_pc     <= '0;
            r_ir_valid  <= 1'b0;
            r_fetch_err <= 1'b0;
            r_wait_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_to_err) begin
                r_imem_req  <= 1'b0;
                r_ir_valid  <= 1'b0;
                r_fetch_err <= 1'b1;
            end else begin
                if (w_issue) begin
                    r_imem_req  <= 1'b1;
                    r_imem_addr <= w_pc_next;
                    r_wait_cnt  <= '0;
                end else if (w_count) begin
                    r_wait_cnt <= w_cnt_inc;
                end
                if (w_load_ir) begin
                    r_ir       <= i_imem_rdata;
                    r_ir_pc    <= i_pc_in;
                    r_ir_valid <= 1'b1;
                    r_imem_req <= 1'b0;
                end
                if (w_consume)
                    r_ir_valid <= 1'b0;
            end
        end
    end

    assign o_pc_next   = w_pc_next;
    assign o_imem_req  = r_imem_req;
    assign o_imem_addr = r_imem_addr;
    assign o_ir        = r_ir;
    assign o_ir_pc     = r_ir_pc;
    assign o_ir_valid  = r_ir_valid;
    assign o_fetch_err = r_fetch_err;

endmodule
